i2c_slave_rx_ctrl: RTL and testbench

Sequencing controller for the I2C slave receive path, running on the system clock. It oversamples SCL/SDA, detects START/STOP, counts bits, and matches the 7-bit address. It drives the ACK/NACK slot and hands each received data byte to the host over a valid/ready buffer. It replaces free-running SCL-clocked shifting with a single-clock-domain, bit-qualified shift and an explicit bus state machine.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_bus_sync.sv | 40 ++++
 rtl/i2c_slave_rx_ctrl.sv | 133 +++++++++++++
 tb/tb_i2c_slave_rx_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C types and constants for the slave receive and transmit controllers.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int I2C_CNT_W = 4;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: two-flop synchronizers on SCL/SDA plus an edge stage that decodes
// SCL edges and START/STOP conditions in the system clock domain.
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_q;
    logic       sda_q;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_q      <= scl_sync_q[1];
            sda_q      <= sda_sync_q[1];
        end
    end

    assign sda_o      = sda_sync_q[1];
    assign scl_rise_o = scl_sync_q[1] & ~scl_q;
    assign scl_fall_o = ~scl_sync_q[1] & scl_q;
    assign start_o    = scl_sync_q[1] & ~sda_sync_q[1] & sda_q;
    assign stop_o     = scl_sync_q[1] & sda_sync_q[1] & ~sda_q;

endmodule

// File: rtl/i2c_slave_rx_ctrl.sv
// i2c_slave_rx_ctrl: I2C slave receive sequencer with 7-bit address match, ACK slot
// generation and a one-byte valid/ready receive buffer, all on the system clock.
module i2c_slave_rx_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       ADDR_HIT,
    output logic       BUSY,
    output logic       OVERRUN
);
    localparam logic [I2C_CNT_W-1:0] CNT_LAST = I2C_CNT_W'(8);

    logic                 sda;
    logic                 scl_rise;
    logic                 scl_fall;
    logic                 start;
    logic                 stop;

    i2c_state_e           state_q;
    logic [I2C_CNT_W-1:0] cnt_q;
    logic [I2C_CNT_W-1:0] cnt_d;
    logic [7:0]           sh_q;
    logic [7:0]           sh_d;
    logic                 ack_q;
    logic                 sda_oe_q;
    logic [7:0]           rx_data_q;
    logic                 rx_valid_q;
    logic                 addr_hit_q;
    logic                 busy_q;
    logic                 overrun_q;

    logic                 shift_en;
    logic                 rx_take;
    logic                 rx_load_ok;
    logic                 addr_match;

    i2c_bus_sync u_sync (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .scl_i      (SCL),
        .sda_i      (SDA_IN),
        .sda_o      (sda),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    assign sh_d       = {sh_q[6:0], sda};
    assign cnt_d      = cnt_q + I2C_CNT_W'(1);
    assign shift_en   = scl_rise & (state_q == ADDR || state_q == DATA) & (cnt_q != CNT_LAST);
    assign rx_take    = rx_valid_q & RX_READY;
    assign rx_load_ok = ~rx_valid_q | RX_READY;
    assign addr_match = (sh_q[7:1] == SLAVE_ADDR) & ~sh_q[0];

    // Bus conditions outrank bit activity; the host handshake runs independently of the bus.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            ack_q      <= I2C_NACK;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            addr_hit_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (rx_take)
                rx_valid_q <= 1'b0;
            if (stop) begin
                state_q    <= IDLE;
                sda_oe_q   <= 1'b0;
                addr_hit_q <= 1'b0;
                busy_q     <= 1'b0;
            end else if (start) begin
                state_q    <= ADDR;
                cnt_q      <= '0;
                sda_oe_q   <= 1'b0;
                addr_hit_q <= 1'b0;
                busy_q     <= 1'b1;
            end else if (shift_en) begin
                sh_q  <= sh_d;
                cnt_q <= cnt_d;
                if (state_q == DATA && cnt_d == CNT_LAST) begin
                    ack_q <= rx_load_ok ? I2C_ACK : I2C_NACK;
                    if (rx_load_ok) begin
                        rx_data_q  <= sh_d;
                        rx_valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
            end else if (scl_fall) begin
                case (state_q)
                    ADDR: if (cnt_q == CNT_LAST) begin
                        state_q    <= addr_match ? ADDR_ACK : IGNORE;
                        sda_oe_q   <= addr_match;
                        addr_hit_q <= addr_match;
                    end
                    DATA: if (cnt_q == CNT_LAST) begin
                        state_q  <= DATA_ACK;
                        sda_oe_q <= (ack_q == I2C_ACK);
                    end
                    ADDR_ACK, DATA_ACK: begin
                        state_q  <= DATA;
                        cnt_q    <= '0;
                        sda_oe_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA_OE   = sda_oe_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign ADDR_HIT = addr_hit_q;
    assign BUSY     = busy_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// tb_i2c_slave_rx_ctrl: directed bus-master stimulus for the I2C slave receive
// controller with hand-computed expected values.
module tb_i2c_slave_rx_ctrl;
    import i2c_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SCL = 1'b1;
    logic       SDA_IN = 1'b1;
    logic       SDA_OE;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY = 1'b1;
    logic       ADDR_HIT;
    logic       BUSY;
    logic       OVERRUN;

    int n_chk = 0;
    int n_fail = 0;
    int rv_rises = 0;
    int oe_cycles = 0;
    logic rv_prev = 1'b0;

    i2c_slave_rx_ctrl #(.SLAVE_ADDR(7'h50)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SCL      (SCL),
        .SDA_IN   (SDA_IN),
        .SDA_OE   (SDA_OE),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .ADDR_HIT (ADDR_HIT),
        .BUSY     (BUSY),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        rv_prev <= RX_VALID;
        if (RX_VALID && !rv_prev)
            rv_rises <= rv_rises + 1;
        if (SDA_OE)
            oe_cycles <= oe_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic i2c_start();
        SDA_IN = 1'b1;
        tick(4);
        SCL = 1'b1;
        tick(8);
        SDA_IN = 1'b0;
        tick(8);
        SCL = 1'b0;
        tick(8);
    endtask

    task automatic i2c_stop();
        SDA_IN = 1'b0;
        tick(4);
        SCL = 1'b1;
        tick(8);
        SDA_IN = 1'b1;
        tick(8);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            SDA_IN = b[i];
            tick(4);
            SCL = 1'b1;
            tick(8);
            SCL = 1'b0;
            tick(4);
        end
    endtask

    task automatic ack_slot(output logic ack);
        SDA_IN = 1'b1;
        tick(4);
        SCL = 1'b1;
        tick(4);
        ack = SDA_OE;
        tick(4);
        SCL = 1'b0;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        ack_slot(ack);
    endtask

    initial begin
        logic ack;
        int rv0;
        int oe0;

        tick(5);
        check("rst_sda_oe", SDA_OE, 0);
        check("rst_rx_data", RX_DATA, 8'h00);
        check("rst_rx_valid", RX_VALID, 0);
        check("rst_addr_hit", ADDR_HIT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_overrun", OVERRUN, 0);
        RST = 1'b1;
        tick(5);

        // Write 0x50, data 0xA5
        rv0 = rv_rises;
        i2c_start();
        check("t1_busy", BUSY, 1);
        send_byte(8'hA0, ack);
        check("t1_addr_ack", ack, 1);
        check("t1_addr_hit", ADDR_HIT, 1);
        send_byte(8'hA5, ack);
        check("t1_data_ack", ack, 1);
        check("t1_rx_data", RX_DATA, 8'hA5);
        check("t1_rv_pulses", rv_rises - rv0, 1);
        check("t1_rx_valid_clr", RX_VALID, 0);
        i2c_stop();
        check("t1_busy_stop", BUSY, 0);
        check("t1_hit_stop", ADDR_HIT, 0);

        // Address 0x51 write: ignored
        rv0 = rv_rises;
        oe0 = oe_cycles;
        i2c_start();
        send_byte(8'hA2, ack);
        check("t2_addr_hit", ADDR_HIT, 0);
        send_byte(8'h33, ack);
        i2c_stop();
        check("t2_oe_never", oe_cycles - oe0, 0);
        check("t2_no_valid", rv_rises - rv0, 0);
        check("t2_rx_data", RX_DATA, 8'hA5);

        // Address 0x50 read: NACK, IGNORE until stop
        i2c_start();
        send_byte(8'hA1, ack);
        check("t3_nack", ack, 0);
        check("t3_state", dut.state_q, IGNORE);
        check("t3_busy", BUSY, 1);
        i2c_stop();
        check("t3_busy_stop", BUSY, 0);
        check("t3_state_idle", dut.state_q, IDLE);

        // Buffer full: second byte NACKed
        RX_READY = 1'b0;
        i2c_start();
        send_byte(8'hA0, ack);
        check("t4_addr_ack", ack, 1);
        send_byte(8'h11, ack);
        check("t4_b1_ack", ack, 1);
        check("t4_b1_data", RX_DATA, 8'h11);
        check("t4_b1_valid", RX_VALID, 1);
        send_byte(8'h22, ack);
        check("t4_b2_nack", ack, 0);
        check("t4_overrun", OVERRUN, 1);
        check("t4_data_kept", RX_DATA, 8'h11);
        i2c_stop();
        check("t4_valid_after_stop", RX_VALID, 1);
        RX_READY = 1'b1;
        tick(2);
        check("t4_valid_consumed", RX_VALID, 0);
        check("t4_overrun_sticky", OVERRUN, 1);

        // Repeated START after address ACK, then stop mid-byte
        i2c_start();
        send_byte(8'hA0, ack);
        check("t5_addr_hit", ADDR_HIT, 1);
        i2c_start();
        check("t5_rs_hit_clr", ADDR_HIT, 0);
        check("t5_rs_cnt", dut.cnt_q, 0);
        send_byte(8'hA0, ack);
        check("t5_addr_ack", ack, 1);
        send_byte(8'h3C, ack);
        check("t5_data_ack", ack, 1);
        check("t5_rx_data", RX_DATA, 8'h3C);
        rv0 = rv_rises;
        send_bits(8'hFF, 3);
        i2c_stop();
        check("t5_discard", RX_DATA, 8'h3C);
        check("t5_no_valid", rv_rises - rv0, 0);
        check("t5_idle", dut.state_q, IDLE);
        check("t5_busy", BUSY, 0);

        // Reset during the data ACK slot
        i2c_start();
        send_byte(8'hA0, ack);
        send_bits(8'h5A, 8);
        SDA_IN = 1'b1;
        tick(4);
        SCL = 1'b1;
        tick(2);
        check("t6_oe_pre", SDA_OE, 1);
        RST = 1'b0;
        tick(1);
        check("t6_oe_rst", SDA_OE, 0);
        check("t6_rx_data", RX_DATA, 8'h00);
        check("t6_rx_valid", RX_VALID, 0);
        check("t6_addr_hit", ADDR_HIT, 0);
        check("t6_busy", BUSY, 0);
        check("t6_overrun", OVERRUN, 0);
        RST = 1'b1;
        tick(2);
        SCL = 1'b0;
        tick(4);
        oe0 = oe_cycles;
        send_byte(8'hA0, ack);
        check("t6_no_ack_wo_start", ack, 0);
        check("t6_oe_never", oe_cycles - oe0, 0);
        i2c_stop();
        check("t6_busy_end", BUSY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
